// File: rtl/uart_inst_loader.sv
// Boot loader: receives a framed program image over 8N1 UART and writes it into
// instruction memory, holding the core in reset until the image checksum verifies.
module uart_inst_loader #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int BOOT_HOLD   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  input  logic              load_en,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst_n,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  rx_state_t        r_rx_state;
  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_byte_valid;
  logic             r_frame_err;

  state_t           r_state;
  logic [7:0]       r_xor;
  logic [7:0]       r_len_lo;
  logic [IDX_W-1:0] r_nwords;
  logic [IDX_W-1:0] r_widx;
  logic [1:0]       r_bidx;
  logic [23:0]      r_word;
  logic [TO_W-1:0]  r_to_cnt;

  logic             w_busy_st;
  logic             w_timeout;
  logic             w_fail;
  logic [31:0]      w_len32;
  logic             w_len_big;
  logic [IDX_W-1:0] w_widx_nxt;

  // Receiver: start bit is re-checked at mid-bit so short glitches are rejected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state   <= RX_IDLE;
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_s1      <= uart_rx;
      r_rx_s2      <= r_rx_s1;
      r_rx_prev    <= r_rx_s2;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_cnt == CNT_W'(HALF - 1)) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == CNT_W'(DIV - 1)) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else r_rx_bit <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == CNT_W'(DIV - 1)) begin
            r_rx_cnt     <= '0;
            r_byte_valid <= r_rx_s2;
            r_frame_err  <= !r_rx_s2;
            r_rx_state   <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign w_len32    = {16'd0, r_rx_shift, r_len_lo};
  assign w_len_big  = w_len32 > (32'd1 << ADDR_W);
  assign w_widx_nxt = r_widx + 1'b1;

  // All paths into ERR are merged here so the sequential block only handles success.
  always_comb begin
    w_busy_st = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                (r_state == S_DATA)   || (r_state == S_CSUM);
    w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !r_byte_valid;
    w_fail    = w_busy_st && (r_frame_err || !load_en || w_timeout);
    if (r_byte_valid && (r_state == S_LEN_HI) && w_len_big) w_fail = 1'b1;
    if (r_byte_valid && (r_state == S_CSUM) && (r_rx_shift != r_xor)) w_fail = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      cpu_rst_n <= (BOOT_HOLD == 0);
      load_busy <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      r_xor     <= '0;
      r_len_lo  <= '0;
      r_nwords  <= '0;
      r_widx    <= '0;
      r_bidx    <= '0;
      r_word    <= '0;
      r_to_cnt  <= '0;
    end else begin
      im_we <= 1'b0;
      if (w_busy_st && !r_byte_valid) r_to_cnt <= r_to_cnt + 1'b1;
      else r_to_cnt <= '0;

      if (w_fail) begin
        r_state   <= S_ERR;
        load_err  <= 1'b1;
        load_done <= 1'b0;
        load_busy <= 1'b0;
        cpu_rst_n <= 1'b0;
      end else if (r_byte_valid) begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (load_en && (r_rx_shift == MAGIC)) begin
              r_state   <= S_LEN_LO;
              load_done <= 1'b0;
              load_err  <= 1'b0;
              load_busy <= 1'b1;
              cpu_rst_n <= 1'b0;
              r_xor     <= '0;
              r_widx    <= '0;
              r_bidx    <= '0;
            end
          end
          S_LEN_LO: begin
            r_len_lo <= r_rx_shift;
            r_xor    <= r_xor ^ r_rx_shift;
            r_state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            r_xor    <= r_xor ^ r_rx_shift;
            r_nwords <= IDX_W'(w_len32);
            r_state  <= (w_len32 == '0) ? S_CSUM : S_DATA;
          end
          S_DATA: begin
            r_xor  <= r_xor ^ r_rx_shift;
            r_bidx <= r_bidx + 1'b1;
            if (r_bidx == 2'd3) begin
              im_we    <= 1'b1;
              im_addr  <= r_widx[ADDR_W-1:0];
              im_wdata <= {r_rx_shift, r_word};
              r_widx   <= w_widx_nxt;
              if (w_widx_nxt == r_nwords) r_state <= S_CSUM;
            end else begin
              r_word <= {r_rx_shift, r_word[23:8]};
            end
          end
          S_CSUM: begin
            r_state   <= S_DONE;
            load_done <= 1'b1;
            load_busy <= 1'b0;
            cpu_rst_n <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
